// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: accepts a 256-bit key, expands one word per cycle into
// w[0..59], and serves the 15 round keys through a registered read port.

module sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc;
    logic [7:0] m;
    acc = 8'h00;
    m   = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) acc = acc ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module aes256_key_expand #(
  parameter int NK = 8,
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [255:0] key_in,
  output logic         key_ready,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy
);

  localparam int NW = 4 * (NR + 1);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  i, i_next;
  logic [31:0] w [0:NW-1];
  logic [31:0] prev, sub_in, sub_out, t, new_word;
  logic [7:0]  rcon;
  logic        load;

  assign key_ready  = (state != EXPAND);
  assign keys_valid = (state == DONE);
  assign busy       = (state == EXPAND);
  assign load       = key_valid & key_ready;

  always_comb begin
    state_next = state;
    i_next     = i;
    case (state)
      IDLE, DONE: begin
        if (key_valid) begin
          state_next = EXPAND;
          i_next     = 6'(NK);
        end
      end
      EXPAND: begin
        if (i == 6'(NW - 1)) state_next = DONE;
        else                 i_next     = i + 6'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      i     <= 6'd0;
    end else begin
      state <= state_next;
      i     <= i_next;
    end
  end

  // Round constant for word i (i multiple of 8): 2^(i/8 - 1) in GF(2^8).
  always_comb begin
    case (i[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    prev   = w[i - 6'd1];
    sub_in = (i[2:0] == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  end

  sbox_lut u_sbox0 (.a(sub_in[7:0]),   .y(sub_out[7:0]));
  sbox_lut u_sbox1 (.a(sub_in[15:8]),  .y(sub_out[15:8]));
  sbox_lut u_sbox2 (.a(sub_in[23:16]), .y(sub_out[23:16]));
  sbox_lut u_sbox3 (.a(sub_in[31:24]), .y(sub_out[31:24]));

  always_comb begin
    case (i[2:0])
      3'd0:    t = sub_out ^ {rcon, 24'h000000};
      3'd4:    t = sub_out;
      default: t = prev;
    endcase
    new_word = w[i - 6'(NK)] ^ t;
  end

  // The word store is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && load) begin
      for (int k = 0; k < NK; k++) w[k] <= key_in[255 - 32*k -: 32];
    end else if (rst && state == EXPAND) begin
      w[i] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                rk_out <= '0;
    else if (rk_idx == 4'd15) rk_out <= '0;
    else                     rk_out <= {w[{rk_idx, 2'b00}], w[{rk_idx, 2'b01}],
                                        w[{rk_idx, 2'b10}], w[{rk_idx, 2'b11}]};
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Scoreboard bench for aes256_key_expand: a reference key schedule model feeds
// an expected-value queue that a negedge monitor drains against rk_out.

module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_valid = 1'b0;
  logic [255:0] key_in = '0;
  logic [3:0]   rk_idx = '0;
  logic         key_ready, keys_valid, busy;
  logic [127:0] rk_out;

  int passed = 0;
  int total  = 0;

  logic [7:0]   sbox [256];
  logic [127:0] model_rk [15];
  logic [127:0] exp_q [$];
  logic         rd_req = 1'b0;
  logic         rd_chk = 1'b0;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes256_key_expand #(.NK(8), .NR(14)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .keys_valid(keys_valid), .rk_idx(rk_idx),
    .rk_out(rk_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  // S-box table built by walking the generator 3 of GF(2^8)* and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] ww [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int k = 0; k < 8; k++) ww[k] = key[255 - 32*k -: 32];
    rc = 8'h01;
    for (int n = 8; n < 60; n++) begin
      tmp = ww[n-1];
      if (n % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (n % 8 == 4) begin
        tmp = subw(tmp);
      end
      ww[n] = ww[n-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) model_rk[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
  endtask

  // Monitor: a read issued before edge E is checked on the negedge after E.
  always @(posedge clk) rd_chk <= rd_req;

  always @(negedge clk) begin
    if (rd_chk) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rk_out_unexpected: got %h with no expected value queued", rk_out);
      end else begin
        chk("rk_out", rk_out, exp_q.pop_front());
      end
    end
  end

  task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp);
    rk_idx = idx;
    rd_req = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic load_key(input logic [255:0] key, input bit hold);
    int lat;
    bit ready_hi;
    key_valid = 1'b1;
    key_in    = key;
    @(posedge clk);
    #1;
    if (hold) key_in = ~key;
    else      key_valid = 1'b0;
    chk("busy_after_accept", 128'(busy), 128'd1);
    chk("keys_valid_at_accept", 128'(keys_valid), 128'd0);
    lat = 0;
    ready_hi = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (keys_valid) begin
        lat = n;
        break;
      end
      if (key_ready) ready_hi = 1'b1;
    end
    key_valid = 1'b0;
    chk("latency", 128'(lat), 128'd52);
    if (hold) chk("ready_low_in_expand", 128'(ready_hi), 128'd0);
    chk("done_flags", 128'({busy, key_ready}), 128'd1);
  endtask

  task automatic read_a3();
    read_rk(4'd0,  128'h603deb1015ca71be2b73aef0857d7781);
    read_rk(4'd1,  128'h1f352c073b6108d72d9810a30914dff4);
    read_rk(4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    read_rk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
  endtask

  initial begin
    logic [255:0] rk;
    build_sbox();

    // Reset held with a key offered: nothing may be accepted.
    rst = 1'b0;
    key_valid = 1'b1;
    key_in = KEY_A3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_key_ready", 128'(key_ready), 128'd1);
    chk("reset_keys_valid", 128'(keys_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_rk_out", rk_out, 128'd0);
    rst = 1'b1;
    key_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("no_accept_in_reset", 128'(busy), 128'd0);

    load_key(KEY_A3, 1'b0);
    read_a3();

    load_key(KEY_A3, 1'b1);
    read_a3();
    read_rk(4'd15, 128'd0);

    expand(256'd0);
    load_key(256'd0, 1'b0);
    read_rk(4'd2, 128'h62636363626363636263636362636363);
    read_rk(4'd14, model_rk[14]);

    // Reset at edge 20 of an expansion.
    key_valid = 1'b1;
    key_in = KEY_A3;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_flags", 128'({key_ready, keys_valid, busy}), 128'd4);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_stays_idle", 128'({keys_valid, busy}), 128'd0);
    load_key(KEY_A3, 1'b0);
    read_rk(4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    read_rk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);

    for (int r = 0; r < 3; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand(rk);
      load_key(rk, 1'($urandom_range(0, 1)));
      for (int idx = 0; idx < 15; idx++) read_rk(4'(idx), model_rk[idx]);
      read_rk(4'd15, 128'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
